// File: rtl/wb8_bus_decoder_pkg.sv
// wb8_bus_decoder_pkg: FSM states, defaults and the base/mask window test shared by the decoder files
package wb8_bus_decoder_pkg;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;
    localparam int IDX_W = 4;
    localparam logic [7:0] ERR_DAT_DEF = 8'hFF;
    function automatic logic in_window(input logic [31:0] adr, input logic [31:0] base, input logic [31:0] mask);
        return (adr & mask) == base;
    endfunction
endpackage

// File: rtl/wb8_bus_decoder_addr_match.sv
// wb8_bus_decoder_addr_match: base/mask window compare with lowest-index priority and default fallback
module wb8_bus_decoder_addr_match
    import wb8_bus_decoder_pkg::*;
#(
    parameter int NSLAVES = 12,
    parameter logic [32*NSLAVES-1:0] SLAVE_BASE = '0,
    parameter logic [32*NSLAVES-1:0] SLAVE_MASK = '0,
    parameter int DEFAULT_SLAVE = 0
) (
    input  logic [31:0]      adr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);
    // Scanning downwards lets the lowest matching index overwrite the others.
    always_comb begin
        hit = DEFAULT_SLAVE < NSLAVES;
        idx = IDX_W'(DEFAULT_SLAVE);
        for (int i = NSLAVES - 1; i >= 0; i--)
            if (in_window(adr, SLAVE_BASE[32*i +: 32], SLAVE_MASK[32*i +: 32])) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
    end
endmodule

// File: rtl/wb8_bus_decoder.sv
// wb8_bus_decoder: Wishbone 8-bit address decoder, response mux, bus watchdog and fault log
module wb8_bus_decoder
    import wb8_bus_decoder_pkg::*;
#(
    parameter int NSLAVES = 12,
    parameter logic [32*NSLAVES-1:0] SLAVE_BASE = '0,
    parameter logic [32*NSLAVES-1:0] SLAVE_MASK = '0,
    parameter int DEFAULT_SLAVE = 0,
    parameter int TIMEOUT = 255,
    parameter logic [7:0] ERR_DAT = ERR_DAT_DEF
) (
    input  logic                   I_wb_clk,
    input  logic                   I_reset_n,
    input  logic [31:0]            I_wb_adr,
    input  logic                   I_wb_stb,
    output logic [7:0]             O_wb_dat,
    output logic                   O_wb_ack,
    output logic                   O_wb_err,
    output logic                   O_wb_stall,
    output logic [NSLAVES-1:0]     O_slv_stb,
    input  logic [8*NSLAVES-1:0]   I_slv_dat,
    input  logic [NSLAVES-1:0]     I_slv_ack,
    input  logic [NSLAVES-1:0]     I_slv_stall,
    output logic                   O_fault,
    output logic [31:0]            O_fault_adr,
    input  logic                   I_fault_clr
);
    state_t state;
    logic hit, live, timed_out;
    logic [IDX_W-1:0] idx, sel, cur;
    logic [31:0] cnt, adr_q;
    logic [15:0] ack_x, stall_x, onehot;
    logic [127:0] dat_x;

    wb8_bus_decoder_addr_match #(
        .NSLAVES(NSLAVES),
        .SLAVE_BASE(SLAVE_BASE),
        .SLAVE_MASK(SLAVE_MASK),
        .DEFAULT_SLAVE(DEFAULT_SLAVE)
    ) u_match (
        .adr(I_wb_adr),
        .hit(hit),
        .idx(idx)
    );

    // Responses are gated by reset so an in-flight cycle dies the moment reset asserts.
    always_comb begin
        ack_x = 16'(I_slv_ack);
        stall_x = 16'(I_slv_stall);
        dat_x = 128'(I_slv_dat);
        cur = state == S_WAIT ? sel : idx;
        onehot = 16'd1 << cur;
        timed_out = TIMEOUT != 0 && cnt == 32'(TIMEOUT);
        live = I_reset_n && I_wb_stb && (state == S_IDLE ? hit : state == S_WAIT);
        O_wb_err = state == S_ERR;
        O_wb_ack = O_wb_err || live && ack_x[cur];
        O_wb_stall = live && stall_x[cur];
        O_wb_dat = O_wb_err ? ERR_DAT : live ? dat_x[{cur, 3'b000} +: 8] : 8'h00;
        O_slv_stb = live && !(state == S_WAIT && timed_out && !ack_x[cur]) ? onehot[NSLAVES-1:0] : '0;
    end

    always_ff @(posedge I_wb_clk or negedge I_reset_n)
        if (!I_reset_n) begin
            state <= S_IDLE;
            sel <= '0;
            cnt <= '0;
            adr_q <= '0;
            O_fault <= 1'b0;
            O_fault_adr <= '0;
        end else begin
            O_fault <= state == S_ERR || O_fault && !I_fault_clr;
            if (state == S_ERR)
                O_fault_adr <= adr_q;
            case (state)
                S_IDLE:
                    if (I_wb_stb) begin
                        adr_q <= I_wb_adr;
                        sel <= idx;
                        cnt <= 32'd1;
                        state <= !hit ? S_ERR : ack_x[idx] ? S_IDLE : S_WAIT;
                    end
                S_WAIT: begin
                    cnt <= cnt + {31'd0, ~&cnt};
                    if (!I_wb_stb || ack_x[sel])
                        state <= S_IDLE;
                    else if (timed_out)
                        state <= S_ERR;
                end
                default: state <= S_IDLE;
            endcase
        end
endmodule
